// File: rtl/sram_model_pkg.sv
// Shared constants and helpers for the dual-port behavioural SRAM model.
package sram_model_pkg;

  localparam int LAT_MAX    = 2;
  // Widest write mask the byte-expansion helper supports (1024-bit words).
  localparam int MAX_WMASKS = 128;

  localparam int COLL_READ_FIRST  = 0;
  localparam int COLL_WRITE_FIRST = 1;

  function automatic logic [8*MAX_WMASKS-1:0] expand_wmask(input logic [MAX_WMASKS-1:0] wm);
    logic [8*MAX_WMASKS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WMASKS; i++) begin
      m[8*i +: 8] = {8{wm[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// LATENCY-deep read pipeline: data, valid and collision flag, with output hold.
module sram_read_pipe
  import sram_model_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  vld_i,
  input  logic                  coll_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  vld_o,
  output logic                  coll_o,
  output logic                  coll_adv_o
);

  if (LATENCY < 1 || LATENCY > LAT_MAX) begin : g_bad_lat
    $fatal(1, "sram_read_pipe: LATENCY must be 1..%0d", LAT_MAX);
  end

  logic [LATENCY-1:0]    vld_q;
  logic [LATENCY-1:0]    coll_q;
  logic [DATA_WIDTH-1:0] data_q [LATENCY];

  // Each stage only loads data when its incoming valid is set, so the last
  // stage naturally holds the previous read result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      coll_q <= '0;
      for (int s = 0; s < LATENCY; s++) data_q[s] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      coll_q[0] <= vld_i & coll_i;
      if (vld_i) data_q[0] <= data_i;
      for (int s = 1; s < LATENCY; s++) begin
        vld_q[s]  <= vld_q[s-1];
        coll_q[s] <= coll_q[s-1];
        if (vld_q[s-1]) data_q[s] <= data_q[s-1];
      end
    end
  end

  // Collision flag entering the output stage this cycle; lets the owner
  // update a counter on the same edge the collision pulse appears.
  if (LATENCY == 1) begin : g_adv1
    assign coll_adv_o = vld_i & coll_i;
  end else begin : g_advn
    assign coll_adv_o = coll_q[LATENCY-2];
  end

  assign data_o = data_q[LATENCY-1];
  assign vld_o  = vld_q[LATENCY-1];
  assign coll_o = coll_q[LATENCY-1];

endmodule

// File: rtl/sram_1rw1r_wmask_model.sv
// 1RW + 1R SRAM model with byte write mask, 1/2-cycle read latency and
// same-address read/write collision detection and counting.
module sram_1rw1r_wmask_model
  import sram_model_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_WMASKS   = DATA_WIDTH / 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0
) (
  input  logic                  clk0,
  input  logic                  rstb,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision,
  output logic [15:0]           collision_count
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % 8 != 0 || NUM_WMASKS != DATA_WIDTH / 8 || NUM_WMASKS > MAX_WMASKS) begin : g_bad_dw
    $fatal(1, "sram_1rw1r_wmask_model: illegal DATA_WIDTH/NUM_WMASKS");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > LAT_MAX) begin : g_bad_lat
    $fatal(1, "sram_1rw1r_wmask_model: READ_LATENCY must be 1 or 2");
  end
  if (WRITE_FIRST != COLL_READ_FIRST && WRITE_FIRST != COLL_WRITE_FIRST) begin : g_bad_wf
    $fatal(1, "sram_1rw1r_wmask_model: WRITE_FIRST must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic                  wr_en, rd0_en, rd1_en, coll_hit;
  logic [DATA_WIDTH-1:0] wbits, old0, merged, rd1_data;
  logic                  p1_coll_adv, p0_coll, p0_coll_adv;
  logic                  unused_p0;
  logic [15:0]           coll_cnt_q, coll_cnt_d;

  assign wr_en    = !csb0 && !web0;
  assign rd0_en   = !csb0 &&  web0;
  assign rd1_en   = !csb1;
  assign coll_hit = wr_en && rd1_en && (addr0 == addr1);

  assign wbits  = DATA_WIDTH'(expand_wmask(MAX_WMASKS'(wmask0)));
  assign old0   = mem_q[addr0];
  assign merged = (old0 & ~wbits) | (din0 & wbits);

  // On a collision addr0 == addr1, so the merged word is exactly what port 1
  // would see after the write lands.
  assign rd1_data = (coll_hit && WRITE_FIRST == COLL_WRITE_FIRST) ? merged : mem_q[addr1];

  always_ff @(posedge clk0) begin
    if (rstb && wr_en) mem_q[addr0] <= merged;
  end

  sram_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_pipe0 (
    .clk_i      (clk0),
    .rst_ni     (rstb),
    .vld_i      (rd0_en),
    .coll_i     (1'b0),
    .data_i     (old0),
    .data_o     (dout0),
    .vld_o      (dout0_valid),
    .coll_o     (p0_coll),
    .coll_adv_o (p0_coll_adv)
  );

  sram_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_pipe1 (
    .clk_i      (clk0),
    .rst_ni     (rstb),
    .vld_i      (rd1_en),
    .coll_i     (coll_hit),
    .data_i     (rd1_data),
    .data_o     (dout1),
    .vld_o      (dout1_valid),
    .coll_o     (collision),
    .coll_adv_o (p1_coll_adv)
  );

  assign unused_p0 = p0_coll ^ p0_coll_adv;

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (p1_coll_adv && coll_cnt_q != 16'hFFFF) coll_cnt_d = coll_cnt_q + 16'd1;
  end

  always_ff @(posedge clk0 or negedge rstb) begin
    if (!rstb) coll_cnt_q <= '0;
    else       coll_cnt_q <= coll_cnt_d;
  end

  assign collision_count = coll_cnt_q;

endmodule

// File: tb/tb_sram_1rw1r_wmask_model.sv
// Scoreboard bench: instance A (latency 1, read-first) and B (latency 2,
// write-first) share stimulus; a negedge monitor pops expected reads.
module tb_sram_1rw1r_wmask_model;

  logic        clk, rstb, csb0, web0, csb1;
  logic [7:0]  wmask0, addr0, addr1;
  logic [63:0] din0;

  logic [63:0] a_d0, a_d1, b_d0, b_d1;
  logic        a_v0, a_v1, a_c, b_v0, b_v1, b_c;
  logic [15:0] a_n, b_n;

  typedef struct {
    logic [63:0] d;
    logic        c;
    logic [15:0] n;
  } exp_t;

  exp_t        q0a[$], q1a[$], q0b[$], q1b[$];
  logic [63:0] last [4];
  logic [63:0] shadow [256];
  logic [15:0] cnt_exp;
  int          checks, failures;
  string       pname [4] = '{"A.port0", "A.port1", "B.port0", "B.port1"};

  sram_1rw1r_wmask_model #(.READ_LATENCY(1), .WRITE_FIRST(0)) dut_a (
    .clk0(clk), .rstb(rstb), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(a_d0), .dout0_valid(a_v0),
    .csb1(csb1), .addr1(addr1), .dout1(a_d1), .dout1_valid(a_v1),
    .collision(a_c), .collision_count(a_n));

  sram_1rw1r_wmask_model #(.READ_LATENCY(2), .WRITE_FIRST(1)) dut_b (
    .clk0(clk), .rstb(rstb), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(b_d0), .dout0_valid(b_v0),
    .csb1(csb1), .addr1(addr1), .dout1(b_d1), .dout1_valid(b_v1),
    .collision(b_c), .collision_count(b_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic pop(input int idx, output exp_t e, output bit got);
    got = 1'b0;
    e   = '{64'h0, 1'b0, 16'h0};
    case (idx)
      0: if (q0a.size() > 0) begin e = q0a.pop_front(); got = 1'b1; end
      1: if (q1a.size() > 0) begin e = q1a.pop_front(); got = 1'b1; end
      2: if (q0b.size() > 0) begin e = q0b.pop_front(); got = 1'b1; end
      default: if (q1b.size() > 0) begin e = q1b.pop_front(); got = 1'b1; end
    endcase
  endtask

  task automatic mon(input int idx, input logic v, input logic [63:0] d,
                     input logic c, input logic [15:0] n);
    exp_t e;
    bit   got;
    bit   p1;
    p1 = (idx % 2) == 1;
    if (v !== 1'b1) begin
      chk({pname[idx], " hold"}, d, last[idx]);
      if (p1) chk({pname[idx], " idle collision"}, {63'h0, c}, 64'h0);
      return;
    end
    pop(idx, e, got);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s unexpected valid actual=%h required=no-read", pname[idx], d);
      return;
    end
    checks--;
    chk({pname[idx], " data"}, d, e.d);
    if (p1) begin
      chk({pname[idx], " collision"}, {63'h0, c}, {63'h0, e.c});
      chk({pname[idx], " count"}, {48'h0, n}, {48'h0, e.n});
    end
    last[idx] = e.d;
  endtask

  always @(negedge clk) begin
    if (rstb === 1'b1) begin
      mon(0, a_v0, a_d0, 1'b0, 16'h0);
      mon(1, a_v1, a_d1, a_c, a_n);
      mon(2, b_v0, b_d0, 1'b0, 16'h0);
      mon(3, b_v1, b_d1, b_c, b_n);
    end else begin
      chk("valid during reset", {60'h0, a_v0, a_v1, b_v0, b_v1}, 64'h0);
    end
  end

  task automatic drive(input bit c0, input bit w0, input logic [7:0] m,
                       input logic [7:0] a0, input logic [63:0] d0,
                       input bit c1, input logic [7:0] a1);
    logic [63:0] wb, mrg;
    bit          wr, coll;
    csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d0;
    csb1 = c1; addr1 = a1;
    for (int b = 0; b < 8; b++) wb[8*b +: 8] = {8{m[b]}};
    wr   = !c0 && !w0;
    coll = wr && !c1 && (a0 == a1);
    mrg  = (shadow[a0] & ~wb) | (d0 & wb);
    if (coll && cnt_exp != 16'hFFFF) cnt_exp++;
    if (!c0 && w0) begin
      q0a.push_back('{shadow[a0], 1'b0, 16'h0});
      q0b.push_back('{shadow[a0], 1'b0, 16'h0});
    end
    if (!c1) begin
      q1a.push_back('{shadow[a1], coll, cnt_exp});
      q1b.push_back('{coll ? mrg : shadow[a1], coll, cnt_exp});
    end
    if (wr) shadow[a0] = mrg;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = 8'h00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " A.dout0"}, a_d0, 64'h0);
    chk({tag, " A.dout1"}, a_d1, 64'h0);
    chk({tag, " B.dout0"}, b_d0, 64'h0);
    chk({tag, " B.dout1"}, b_d1, 64'h0);
    chk({tag, " flags"}, {58'h0, a_v0, a_v1, a_c, b_v0, b_v1, b_c}, 64'h0);
    chk({tag, " A.count"}, {48'h0, a_n}, 64'h0);
    chk({tag, " B.count"}, {48'h0, b_n}, 64'h0);
  endtask

  initial begin
    checks = 0; failures = 0; cnt_exp = 16'h0;
    for (int i = 0; i < 4; i++) last[i] = 64'h0;
    for (int i = 0; i < 256; i++) shadow[i] = 64'h0;
    rstb = 1'b1; csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    wmask0 = 8'h00; addr0 = 8'h00; addr1 = 8'h00; din0 = 64'h0;
    #2 rstb = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;

    // Masked write, then both ports read the same address (no collision).
    drive(0, 0, 8'hFF, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 1, 8'h00);
    drive(0, 0, 8'b0000_0101, 8'h10, 64'h0, 1, 8'h00);
    drive(0, 1, 8'h00, 8'h10, 64'h0, 0, 8'h10);
    idle(3);
    chk("masked A.dout0", a_d0, 64'hFFFF_FFFF_FF00_FF00);
    chk("masked A.dout1", a_d1, 64'hFFFF_FFFF_FF00_FF00);
    chk("masked B.dout1", b_d1, 64'hFFFF_FFFF_FF00_FF00);
    chk("same-addr reads no collision", {48'h0, a_n}, 64'h0);

    // Collisions: read-first vs write-first, then a zero-mask write.
    drive(0, 0, 8'hFF, 8'h20, 64'hA5, 1, 8'h00);
    drive(0, 0, 8'hFF, 8'h20, 64'h5A, 0, 8'h20);
    idle(3);
    chk("coll A.dout1", a_d1, 64'hA5);
    chk("coll B.dout1", b_d1, 64'h5A);
    chk("coll A.count", {48'h0, a_n}, 64'h1);
    chk("coll B.count", {48'h0, b_n}, 64'h1);
    drive(0, 0, 8'h00, 8'h20, 64'hFFFF, 0, 8'h20);
    idle(3);
    chk("mask0 coll B.dout1", b_d1, 64'h5A);
    chk("mask0 coll A.count", {48'h0, a_n}, 64'h2);

    // Throughput: fill, then 256 back-to-back port-1 reads with port-0 writes.
    for (int i = 0; i < 256; i++) drive(0, 0, 8'hFF, 8'(i), 64'(i), 1, 8'h00);
    for (int i = 0; i < 256; i++)
      drive(0, 0, 8'hFF, 8'(i + 128), 64'((i + 128) % 256), 0, 8'(i));
    idle(3);
    chk("stream A.dout1 last", a_d1, 64'hFF);
    chk("stream B.dout1 last", b_d1, 64'hFF);
    chk("stream A.dout0 held", a_d0, 64'hFFFF_FFFF_FF00_FF00);
    drive(0, 1, 8'h00, 8'hFF, 64'h0, 0, 8'h00);
    drive(0, 1, 8'h00, 8'h00, 64'h0, 1, 8'h00);
    idle(3);
    chk("addr0 read A.dout0", a_d0, 64'h0);
    chk("addr255 B.dout0", b_d0, 64'h0);

    // Reset with reads in flight; writes during reset are ignored.
    drive(0, 1, 8'h00, 8'h05, 64'h0, 0, 8'h06);
    csb0 = 1'b1; csb1 = 1'b1;
    @(negedge clk); #2;
    rstb = 1'b0;
    q0a.delete(); q1a.delete(); q0b.delete(); q1b.delete();
    for (int i = 0; i < 4; i++) last[i] = 64'h0;
    cnt_exp = 16'h0;
    #1 chk_zero("async reset");
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 8'hFF; addr0 = 8'h06; din0 = 64'hDEAD;
    csb1 = 1'b0; addr1 = 8'h06;
    repeat (2) @(posedge clk);
    #1 csb0 = 1'b1; csb1 = 1'b1; rstb = 1'b1;
    idle(2);
    chk_zero("after reset");
    drive(1, 1, 8'h00, 8'h00, 64'h0, 0, 8'h06);
    idle(3);
    chk("write during reset ignored A", a_d1, 64'h06);
    chk("write during reset ignored B", b_d1, 64'h06);

    // Saturate the collision counter.
    for (int i = 0; i < 65540; i++)
      drive(0, 0, (i % 2) ? 8'hFF : 8'h00, 8'h30, 64'(i), 0, 8'h30);
    idle(3);
    chk("sat A.count", {48'h0, a_n}, 64'hFFFF);
    chk("sat B.count", {48'h0, b_n}, 64'hFFFF);

    chk("A.port0 drained", 64'(q0a.size()), 64'h0);
    chk("A.port1 drained", 64'(q1a.size()), 64'h0);
    chk("B.port0 drained", 64'(q0b.size()), 64'h0);
    chk("B.port1 drained", 64'(q1b.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_1rw1r_wmask_model.md
# sram_1rw1r_wmask_model

Parametrised behavioural SRAM model with one read/write port and one read-only port, per-byte write mask, configurable read latency and detection of same-address read/write collisions. It is the drop-in simulation model for the dual-port OpenRAM macros used in the FreePDK45 flow. It also runs under synthesis for FPGA prototyping, so it has single-edge timing and an explicit reset of all control/output state.

## Interface
- DATA_WIDTH, 64, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 8, address width; RAM_DEPTH = 1 << ADDR_WIDTH
- NUM_WMASKS, DATA_WIDTH/8, write-mask bits, one per byte
- READ_LATENCY, 1, cycles from sampling edge to data; legal values 1 or 2
- WRITE_FIRST, 0, port-1 collision mode: 0 returns old data, 1 returns newly written data
- clk0  in  1  clock; all activity on the rising edge
- rstb  in  1  asynchronous active-low reset
- csb0  in  1  port 0 active-low chip select
- web0  in  1  port 0 active-low write enable
- wmask0  in  NUM_WMASKS  port 0 byte write mask; bit i enables din0[8i+7:8i]
- addr0  in  ADDR_WIDTH  port 0 address
- din0  in  DATA_WIDTH  port 0 write data
- dout0  out  DATA_WIDTH  port 0 read data
- dout0_valid  out  1  one-cycle pulse when dout0 carries new read data
- csb1  in  1  port 1 active-low chip select (read only)
- addr1  in  ADDR_WIDTH  port 1 address
- dout1  out  DATA_WIDTH  port 1 read data
- dout1_valid  out  1  one-cycle pulse when dout1 carries new read data
- collision  out  1  one-cycle pulse, aligned with dout1_valid, for a same-address collision
- collision_count  out  16  saturating count of collisions since reset

## Operation
- All inputs are registered on the rising edge of clk0. There are no negedge operations.
- Port 0 write (csb0=0, web0=0): the bytes of mem[addr0] selected by wmask0 take the value of din0 at that edge. Unmasked bytes are unchanged. wmask0=0 is a legal no-op write.
- Port 0 read (csb0=0, web0=1): reads mem[addr0]. A write produces no read data: dout0 holds its value and dout0_valid stays 0.
- Port 1 read (csb1=0): reads mem[addr1].
- Collision: port 1 read and port 0 write to the same address on the same edge.
  - If WRITE_FIRST=0, dout1 gets the pre-write word.
  - If WRITE_FIRST=1, dout1 gets the merged post-write word.
  - A write with wmask0=0 still counts as a collision.
- Each collision pulses collision together with that read's dout1_valid. collision_count increments by 1 and saturates at 16'hFFFF.
- Deselected ports (csb=1) do nothing. Their dout holds and their valid is 0.
- Reset (rstb=0, asynchronous) forces:
  - dout0, dout1 = 0
  - dout0_valid, dout1_valid, collision = 0
  - collision_count = 0
  - all read-pipeline stages cleared, so reads in flight at reset are dropped and never produce a valid
- Memory contents are not cleared by reset.
- Inputs sampled while rstb=0 are ignored.
- Out-of-range parameters (DATA_WIDTH%8≠0, READ_LATENCY∉{1,2}) trigger $fatal at elaboration.

## Timing
- Read sampled at edge N produces dout/valid after edge N+READ_LATENCY.
- Valid is high for exactly one cycle. dout holds until the next completed read on that port.
- A write at edge N is visible to any read sampled at edge N+1 or later, on either port.
- Back-to-back reads every cycle give one valid per cycle, with full throughput at both latencies.
- Reads at addresses 0 and RAM_DEPTH-1 need no special handling; there is no address wrap.
- Simultaneous reads on both ports to the same address are not a collision. Both return the same data.

## Structure
- Package sram_model_pkg holds:
  - localparam LAT_MAX = 2
  - collision-mode constants COLL_READ_FIRST / COLL_WRITE_FIRST
  - function expand_wmask(NUM_WMASKS → DATA_WIDTH bit mask)
- Sub-module sram_read_pipe holds the READ_LATENCY-deep data+valid+collision shift pipeline with async reset and output hold. It is instantiated once per port; port 0 ties its collision input to 0.
- The top level contains the memory array, the input registers, the write merge and the collision compare.

## Test plan
- Reset mid-read: with READ_LATENCY=2, issue a read, then assert rstb=0 one cycle later → no valid pulse; dout0=dout1=0 and collision_count=0 after release.
- Masked write: write 64'hFFFF_FFFF_FFFF_FFFF to addr 8'h10, then write 64'h0 with wmask0=8'b0000_0101 → read returns 64'hFFFF_FFFF_FF00_FF00 at edge N+READ_LATENCY.
- Collision, WRITE_FIRST=0: mem[8'h20]=64'hA5, then port 0 writes 64'h5A while port 1 reads 8'h20 → dout1=64'hA5, collision pulse, count=1. With WRITE_FIRST=1 → dout1=64'h5A.
- Throughput: 256 consecutive port-1 reads, addresses 0..255, after filling mem[i]=i → 256 consecutive valid pulses with dout1=i. Port 0 writes leave dout0 unchanged and dout0_valid=0.
- Saturation: force 65 540 collisions → collision_count holds 16'hFFFF; collision still pulses each time.
